// File: rtl/sonar_serial_tx.sv
// sonar_serial_tx: sends one selected angle/distance character as a 7E2 frame, then pulses serial_pronto.
module sonar_serial_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        transmissao,
  input  logic [2:0]  sel_transmissao,
  input  logic [23:0] angulo,
  input  logic [11:0] distancia,
  output logic        saida_serial,
  output logic        serial_pronto,
  output logic [3:0]  db_estado
);
  typedef enum logic [3:0] {IDLE = 4'd0, START = 4'd1, DATA = 4'd2, PARITY = 4'd3, STOP = 4'd4, DONE = 4'd5} state_t;
  state_t state, state_n;
  logic [15:0] baud, baud_n;
  logic [2:0] bit_cnt, bit_n;
  logic [6:0] char_q, char_n, char_sel;
  logic line_n;
  logic tc;
  assign tc = baud == 16'(BAUD_DIV - 1);
  assign db_estado = state;
  always_comb begin
    char_sel = 7'h23;
    case (sel_transmissao)
      3'd0: char_sel = angulo[22:16];
      3'd1: char_sel = angulo[14:8];
      3'd2: char_sel = angulo[6:0];
      3'd3: char_sel = 7'h2C;
      3'd4: char_sel = {3'b011, distancia[11:8]};
      3'd5: char_sel = {3'b011, distancia[7:4]};
      3'd6: char_sel = {3'b011, distancia[3:0]};
      default: char_sel = 7'h23;
    endcase
  end
  always_comb begin
    state_n = state;
    baud_n = tc ? 16'd0 : baud + 16'd1;
    bit_n = bit_cnt;
    char_n = char_q;
    case (state)
      IDLE: begin
        baud_n = 16'd0;
        bit_n = 3'd0;
        if (transmissao) begin
          state_n = START;
          char_n = char_sel;
        end
      end
      START: state_n = tc ? DATA : START;
      DATA: if (tc) begin
        bit_n = bit_cnt == 3'd6 ? 3'd0 : bit_cnt + 3'd1;
        state_n = bit_cnt == 3'd6 ? PARITY : DATA;
      end
      PARITY: state_n = tc ? STOP : PARITY;
      // two stop bits reuse the bit counter to time 2*BAUD_DIV
      STOP: if (tc) begin
        bit_n = bit_cnt == 3'd1 ? 3'd0 : bit_cnt + 3'd1;
        state_n = bit_cnt == 3'd1 ? DONE : STOP;
      end
      DONE: begin
        state_n = IDLE;
        baud_n = 16'd0;
      end
      default: state_n = IDLE;
    endcase
    line_n = state_n == START ? 1'b0 : state_n == DATA ? char_n[bit_n] : state_n == PARITY ? ^char_n : 1'b1;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      baud <= 16'd0;
      bit_cnt <= 3'd0;
      char_q <= 7'd0;
      saida_serial <= 1'b1;
      serial_pronto <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      char_q <= char_n;
      saida_serial <= line_n;
      serial_pronto <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_sonar_serial_tx.sv
// tb_sonar_serial_tx: frame-timeline model, line receiver and directed character tests.
module tb_sonar_serial_tx;
  localparam int B = 4;
  logic clock = 0;
  logic reset = 1;
  logic transmissao = 0;
  logic [2:0] sel = 0;
  logic [23:0] angulo = 0;
  logic [11:0] distancia = 0;
  logic saida_serial, serial_pronto;
  logic [3:0] db_estado;
  int errors = 0, checks = 0, cyc = 0;
  int m_pos = -1;
  logic [10:0] m_frame = 0;
  int rx_cnt = -1;
  logic [10:0] rx_bits = 0;
  logic [10:0] rx_q[$];
  int pr_q[$], st_q[$];

  sonar_serial_tx #(.BAUD_DIV(B)) dut (
    .clock(clock), .reset(reset), .transmissao(transmissao), .sel_transmissao(sel),
    .angulo(angulo), .distancia(distancia), .saida_serial(saida_serial),
    .serial_pronto(serial_pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] build(input logic [2:0] s, input logic [23:0] a, input logic [11:0] d);
    logic [6:0] c;
    case (s)
      3'd0: c = a[22:16];
      3'd1: c = a[14:8];
      3'd2: c = a[6:0];
      3'd3: c = 7'h2C;
      3'd4: c = 7'h30 | 7'(d[11:8]);
      3'd5: c = 7'h30 | 7'(d[7:4]);
      3'd6: c = 7'h30 | 7'(d[3:0]);
      default: c = 7'h23;
    endcase
    return {2'b11, ^c, c, 1'b0};
  endfunction

  // Model: position within an 11-bit-time frame, -1 when idle, 11*B is the pronto cycle
  always @(posedge clock or posedge reset) begin
    if (reset) m_pos = -1;
    else if (m_pos < 0) begin
      if (transmissao) begin
        m_frame = build(sel, angulo, distancia);
        m_pos = 0;
      end
    end else if (m_pos == 11 * B) m_pos = -1;
    else m_pos++;
  end

  function automatic int exp_state(input int p);
    return p < 0 ? 0 : p < B ? 1 : p < 8 * B ? 2 : p < 9 * B ? 3 : p < 11 * B ? 4 : 5;
  endfunction

  always @(negedge clock) if (!reset) begin
    chk("line", int'(saida_serial), (m_pos < 0 || m_pos >= 11 * B) ? 1 : int'(m_frame[m_pos / B]));
    chk("pronto", int'(serial_pronto), int'(m_pos == 11 * B));
    chk("estado", int'(db_estado), exp_state(m_pos));
  end

  always @(negedge clock) begin
    if (reset) rx_cnt = -1;
    else begin
      if (rx_cnt < 0) begin
        if (saida_serial == 1'b0) begin
          rx_cnt = 0;
          st_q.push_back(cyc);
        end
      end else rx_cnt++;
      if (rx_cnt >= 0 && rx_cnt % B == B / 2) rx_bits[rx_cnt / B] = saida_serial;
      if (rx_cnt == 10 * B + B / 2) begin
        rx_q.push_back(rx_bits);
        rx_cnt = -1;
      end
      if (serial_pronto) pr_q.push_back(cyc);
    end
  end

  task automatic wait_state(input int code, input int lim);
    int n = 0;
    while (int'(db_estado) != code && n < lim) begin
      @(negedge clock);
      n++;
    end
    chk("wait_state", int'(db_estado), code);
  endtask

  task automatic wait_pronto(input int lim);
    int n = 0;
    while (!serial_pronto && n < lim) begin
      @(negedge clock);
      n++;
    end
    chk("wait_pronto", int'(serial_pronto), 1);
  endtask

  task automatic check_frame(input string name, input logic [10:0] exp);
    if (rx_q.size() == 0) chk(name, -1, int'(exp));
    else chk(name, int'(rx_q.pop_front()), int'(exp));
  endtask

  task automatic clear_q();
    rx_q.delete();
    pr_q.delete();
    st_q.delete();
  endtask

  task automatic send(input logic [2:0] s);
    sel = s;
    transmissao = 1;
    wait_pronto(100);
    transmissao = 0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    string s;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_line", int'(saida_serial), 1);
    chk("rst_pronto", int'(serial_pronto), 0);
    chk("rst_estado", int'(db_estado), 0);
    reset = 0;
    sel = 3;
    transmissao = 1;
    wait_state(2, 50);
    @(posedge clock);
    #1;
    reset = 1;
    transmissao = 0;
    #1;
    chk("midrst_line", int'(saida_serial), 1);
    chk("midrst_pronto", int'(serial_pronto), 0);
    chk("midrst_estado", int'(db_estado), 0);
    @(posedge clock);
    #1;
    reset = 0;
    clear_q();
    repeat (20) @(posedge clock);
    #1;
    chk("post_rst_line", int'(saida_serial), 1);
    chk("post_rst_no_pronto", pr_q.size(), 0);
    chk("post_rst_no_frame", rx_q.size(), 0);

    angulo = 24'h303435;
    send(3'd1);
    if (pr_q.size() > 0 && st_q.size() > 0) chk("t2_latency", pr_q[0] - st_q[0], 44);
    else chk("t2_latency", -1, 44);
    check_frame("t2_frame", {2'b11, 1'b1, 7'h34, 1'b0});

    clear_q();
    distancia = 12'h123;
    send(3'd6);
    check_frame("t3_sel6", {2'b11, 1'b0, 7'h33, 1'b0});
    send(3'd4);
    check_frame("t3_sel4", {2'b11, 1'b1, 7'h31, 1'b0});

    clear_q();
    angulo = 24'h303930;
    distancia = 12'h057;
    sel = 0;
    transmissao = 1;
    for (int i = 0; i < 8; i++) begin
      wait_pronto(100);
      if (i < 7) sel = 3'(i + 1);
      else transmissao = 0;
      @(negedge clock);
    end
    repeat (40) @(posedge clock);
    #1;
    chk("t4_pronto_count", pr_q.size(), 8);
    chk("t4_frame_count", rx_q.size(), 8);
    for (int i = 1; i < pr_q.size(); i++) chk("t4_period", pr_q[i] - pr_q[i - 1], 46);
    s = "090,057#";
    for (int i = 0; i < 8; i++) begin
      if (rx_q.size() == 0) chk("t4_char", -1, int'(s[i]));
      else begin
        rx_bits = rx_q.pop_front();
        chk("t4_char", int'(rx_bits[7:1]), int'(s[i]));
        chk("t4_parity", int'(rx_bits[8]), int'(^rx_bits[7:1]));
      end
    end
    chk("t4_idle_estado", int'(db_estado), 0);

    clear_q();
    sel = 3;
    transmissao = 1;
    wait_state(3, 100);
    transmissao = 0;
    wait_pronto(100);
    repeat (60) @(posedge clock);
    #1;
    check_frame("t5_frame", {2'b11, 1'b1, 7'h2C, 1'b0});
    chk("t5_pronto_count", pr_q.size(), 1);
    chk("t5_no_more", rx_q.size(), 0);
    chk("t5_estado", int'(db_estado), 0);

    clear_q();
    sel = 0;
    angulo = 24'h303435;
    transmissao = 1;
    wait_state(2, 50);
    sel = 7;
    angulo = 24'h373737;
    wait_pronto(100);
    transmissao = 0;
    repeat (3) @(posedge clock);
    #1;
    check_frame("t6_latched", {2'b11, 1'b0, 7'h30, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/sonar_serial_tx.md
Name: sonar_serial_tx

Overview:
Serial output stage directly downstream of the sonar control unit. While the control unit holds transmissao high, this block picks one of 8 characters by sel_transmissao: 3 angle digits, ',', 3 distance digits, '#'. It sends that character as a 7E2 asynchronous frame on saida_serial, then pulses serial_pronto so the control unit advances to the next character.

Parameters:
BAUD_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535; 16-bit baud counter.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
transmissao  input  1  level request from control unit; held high for the whole character slot
sel_transmissao  input  3  character index, stable while transmissao=1
angulo  input  24  angle as 3 ASCII chars: [23:16] hundreds, [15:8] tens, [7:0] units (from angle ROM)
distancia  input  12  distance BCD: [11:8] hundreds, [7:4] tens, [3:0] units
saida_serial  output  1  serial line, idle high
serial_pronto  output  1  one-cycle pulse: character fully sent
db_estado  output  4  current FSM state code, debug

Behaviour:
- Reset (async) forces: state IDLE, saida_serial=1, serial_pronto=0, db_estado=0, baud counter=0, bit counter=0. Reset mid-frame drops the frame immediately and raises the line to 1.
- Character map, 7 bits, latched on frame start:
  - sel 0/1/2: angulo[22:16] / [14:8] / [6:0]
  - sel 3: 7'h2C (',')
  - sel 4/5/6: {3'b011, BCD digit} from distancia[11:8] / [7:4] / [3:0]
  - sel 7: 7'h23 ('#')
  - BCD digits >9 are not checked; they are sent as 0x30|d.
- Frame format, 11 bits, each exactly BAUD_DIV cycles: start(0), data bit0..bit6 LSB first, even parity (XOR of the 7 data bits), stop(1), stop(1).
- FSM states, db_estado code in parentheses:
  - IDLE(0): saida_serial=1. If transmissao=1, latch the character and enter START.
  - START(1): line 0 for BAUD_DIV cycles, then DATA.
  - DATA(2): bit counter 0..6, each bit BAUD_DIV cycles, then PARITY.
  - PARITY(3): parity bit for BAUD_DIV cycles, then STOP.
  - STOP(4): line 1 for 2*BAUD_DIV cycles, then DONE.
  - DONE(5): serial_pronto=1 for exactly one cycle, line 1, then IDLE unconditionally.
- Baud counter counts 0..BAUD_DIV-1; on terminal count it advances the bit or state and wraps to 0.
- Outputs are registered. saida_serial changes only on state/bit boundaries, so the line is glitch-free.
- Latency:
  - transmissao sampled high in IDLE → saida_serial=0 on the next cycle.
  - First START cycle → serial_pronto pulse: 11*BAUD_DIV cycles.
  - Character slot period when transmissao stays high: 11*BAUD_DIV+2 cycles (IDLE + frame + DONE).
- The mandatory IDLE cycle after DONE lets the control unit register its next TX state. A new sel_transmissao is therefore sampled one cycle after the pronto pulse, never the stale index.
- If transmissao falls mid-frame (control unit reset via ligar=0), the current frame still completes and serial_pronto still pulses; the block then stays in IDLE.
- sel_transmissao, angulo and distancia changing mid-frame have no effect: the character is latched at frame start.
- db_estado is the combinational state code; values 6..15 never occur.

Test Plan:
1. Reset checks, BAUD_DIV=4: assert reset mid-DATA → within the same cycle saida_serial=1, serial_pronto=0, db_estado=0. After release with transmissao=0 for 20 cycles → line stays 1, no pronto pulse.
2. Angle digit: angulo="045" (24'h303435), sel=1, transmissao=1 → line sequence (4 cycles each) 0 | 0,0,1,0,1,1,0 | 1 | 1,1. serial_pronto pulses exactly 44 cycles after the first start cycle.
3. Distance digit and parity 0: distancia=12'h123, sel=6 → char 0x33, data 1,1,0,0,1,1,0, parity 0. sel=4 → char 0x31, parity 1.
4. Full sweep: model control-unit stepping on serial_pronto through sel 0..7 with angulo="090", distancia=12'h057 → decoded bytes "090,057#". Exactly 8 pronto pulses, 46 cycles apart; line idle after the last.
5. Abort: drop transmissao at PARITY of sel=3 → frame 0x2C completes with parity 1 and stops, one pronto pulse, then IDLE (db_estado=0) with no further frames.
6. Mid-frame input change: switch sel 0→7 and angulo during DATA → the transmitted byte is still the originally latched character.
